pool_fmap_frame_buffer: RTL and testbench
=========================================

// Module: pool_fmap_frame_buffer
// PURPOSE
//  Frame buffer directly downstream of stage-1 conv+pooling. Captures one full
//  pooled feature map (POOL_W x POOL_H pixels, CI channels packed per beat) from
//  the free-running pooling valid stream, then replays it in raster order to the
//  stage-2 conv feeder over a valid/ready handshake with backpressure.
// PARAMETERS
//  CI      3    channels per pixel beat (pooling output channels)
//  IBW     19   bits per channel (signed, passed through unmodified)
//  POOL_W  12   pooled map width (pixels per row)
//  POOL_H  12   pooled map height (rows)
//  AW      8    address width; must satisfy 2**AW >= POOL_W*POOL_H
// PORTS
//  clk         in   1       system clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  i_in_valid  in   1       pooling output beat valid (no ready; cannot stall)
//  i_in_fmap   in   CI*IBW  pooled pixel, ch c at [c*IBW +: IBW]
//  o_ot_valid  out  1       replay beat valid
//  i_ot_ready  in   1       downstream accepts beat when valid&ready
//  o_ot_fmap   out  CI*IBW  replayed pixel, same packing as i_in_fmap
//  o_ot_last   out  1       high with the final pixel (index N-1) of the frame
//  o_busy      out  1       high in LOAD/STREAM (buffer not accepting writes)
//  o_drop      out  1       1-cycle pulse: an input beat arrived while busy
// BEHAVIOUR
//  N = POOL_W*POOL_H. Storage: N x (CI*IBW) array, raster order, addr = y*POOL_W+x.
//  States: FILL (reset state), LOAD, STREAM.
//  Reset (async, any state): state=FILL, wr_cnt=0, rd_addr=0; o_ot_valid=0,
//   o_ot_last=0, o_busy=0, o_drop=0, o_ot_fmap=0. Array contents not cleared.
//  FILL: each edge with i_in_valid writes i_in_fmap to mem[wr_cnt], wr_cnt++.
//   Edge writing index N-1 -> LOAD, wr_cnt<=0. Data bits never altered/resized.
//  LOAD: one cycle; reads mem[0] into output reg; next edge o_ot_valid<=1,
//   o_ot_fmap<=mem[0], o_ot_last<=(N==1), state -> STREAM.
//   => last input beat at edge E gives first o_ot_valid high after edge E+2.
//  STREAM: o_ot_fmap/o_ot_last held stable while o_ot_valid & !i_ot_ready.
//   Edge with valid&ready on index k<N-1: present index k+1 next cycle, no bubble
//   (sustained 1 beat/clk with ready tied high).
//   Edge with valid&ready on index N-1: o_ot_valid<=0, o_ot_last<=0, state->FILL;
//   i_in_valid on that same edge is dropped (o_drop pulse); next edge may write idx 0.
//  o_busy = (state!=FILL), combinational from state register.
//  o_drop: registered; high for one cycle after any edge where i_in_valid=1 and
//   state!=FILL. Dropped beats do not advance wr_cnt.
//  o_ot_valid never deasserts without a handshake except by reset.
//  Partial frame (wr_cnt<N) waits indefinitely in FILL; only reset discards it.
// TESTING
//  1 Fill 144 beats, ch c = {addr,c} pattern, ready=1 -> 144 consecutive beats
//    in addr order 0..143, o_ot_last only on beat 143, first valid 2 edges after
//    last write, then o_busy=0.
//  2 Same fill, ready random 50% -> identical 144-beat sequence, o_ot_fmap stable
//    on every stalled cycle, o_ot_last with addr 143 only.
//  3 Inject 5 input beats during STREAM -> 5 o_drop pulses, output data unchanged,
//    next frame starts at addr 0 after return to FILL.
//  4 Assert reset_n=0 after 70 writes, release, write full 144-beat frame B ->
//    replay is exactly frame B; all outputs 0 during reset.
//  5 Reset during STREAM at beat 40 with ready=0 -> o_ot_valid drops immediately
//    (async), state FILL, o_busy=0.
//  6 Two back-to-back frames with i_in_valid gaps of 0..3 cycles -> both replayed
//    intact; frame-2 beats arriving before frame-1 last handshake flagged o_drop.

Source files
------------

// File: rtl/pool_fmap_frame_buffer.sv
// Single-frame buffer between stage-1 pooling and the stage-2 conv feeder.
// Captures one pooled feature map, then replays it in raster order with backpressure.
module pool_fmap_frame_buffer #(
    parameter int CI     = 3,
    parameter int IBW    = 19,
    parameter int POOL_W = 12,
    parameter int POOL_H = 12,
    parameter int AW     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_in_valid,
    input  logic [CI*IBW-1:0]   i_in_fmap,
    output logic                o_ot_valid,
    input  logic                i_ot_ready,
    output logic [CI*IBW-1:0]   o_ot_fmap,
    output logic                o_ot_last,
    output logic                o_busy,
    output logic                o_drop
);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // S_FILL  | accepting pooled beats into mem[wr_cnt]
    // S_LOAD  | frame complete; fetch mem[0], then present it (two edges)
    // S_STREAM| replaying mem[rd_addr] over valid/ready, inputs dropped

    localparam int N  = POOL_W * POOL_H;
    localparam int DW = CI * IBW;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [0:N-1];
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_next;
    logic [DW-1:0] load_buf;
    logic          load_rdy;
    logic          wr_en;

    assign wr_en   = (state == S_FILL) && i_in_valid;
    assign rd_next = rd_addr + AW'(1);
    assign o_busy  = (state != S_FILL);

    // Storage is left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= i_in_fmap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FILL;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            load_buf   <= '0;
            load_rdy   <= 1'b0;
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            o_ot_fmap  <= '0;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= i_in_valid && (state != S_FILL);

            case (state)
                S_FILL: begin
                    if (i_in_valid) begin
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt <= '0;
                            state  <= S_LOAD;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end

                S_LOAD: begin
                    if (!load_rdy) begin
                        load_buf <= mem[0];
                        load_rdy <= 1'b1;
                    end else begin
                        load_rdy   <= 1'b0;
                        o_ot_fmap  <= load_buf;
                        o_ot_valid <= 1'b1;
                        o_ot_last  <= (N == 1);
                        rd_addr    <= '0;
                        state      <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    // Output registers only move on a handshake, so a stalled beat holds.
                    if (o_ot_valid && i_ot_ready) begin
                        if (rd_addr == LAST_IDX) begin
                            o_ot_valid <= 1'b0;
                            o_ot_last  <= 1'b0;
                            rd_addr    <= '0;
                            state      <= S_FILL;
                        end else begin
                            rd_addr   <= rd_next;
                            o_ot_fmap <= mem[rd_next];
                            o_ot_last <= (rd_next == LAST_IDX);
                        end
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_fmap_frame_buffer.sv
// Bench for pool_fmap_frame_buffer: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations on latency, counts and reset.
module tb_pool_fmap_frame_buffer;

    localparam int CI  = 3;
    localparam int IBW = 19;
    localparam int DW  = CI * IBW;
    localparam int N   = 144;

    logic          clk;
    logic          reset_n;
    logic          i_in_valid;
    logic [DW-1:0] i_in_fmap;
    logic          o_ot_valid;
    logic          i_ot_ready;
    logic [DW-1:0] o_ot_fmap;
    logic          o_ot_last;
    logic          o_busy;
    logic          o_drop;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int beats = 0;
    int hs_in_frame = 0;
    int last_idx = -1;
    int drops = 0;

    pool_fmap_frame_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (i_in_valid),
        .i_in_fmap  (i_in_fmap),
        .o_ot_valid (o_ot_valid),
        .i_ot_ready (i_ot_ready),
        .o_ot_fmap  (o_ot_fmap),
        .o_ot_last  (o_ot_last),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] pix(input logic [7:0] tag, input int a);
        logic [DW-1:0] p;
        p = '0;
        for (int c = 0; c < CI; c++) begin
            p[c*IBW +: IBW] = {tag, a[7:0], c[2:0]};
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait budget expired t=%0t", name, $time);
    endtask

    // Frame-level model: which frame is stored, whether the buffer is busy,
    // and which pixel index should currently be on the output.
    logic [DW-1:0] m_mem [0:N-1];
    int   m_wr, m_idx, m_load;
    logic m_busy, m_valid, m_drop;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_drop  <= 1'b0;
            m_wr    <= 0;
            m_idx   <= 0;
            m_load  <= 0;
        end else begin
            m_drop <= i_in_valid && m_busy;
            if (i_in_valid && !m_busy) begin
                m_mem[m_wr] <= i_in_fmap;
                if (m_wr == N - 1) begin
                    m_wr   <= 0;
                    m_busy <= 1'b1;
                    m_load <= 2;
                end else begin
                    m_wr <= m_wr + 1;
                end
            end
            if (m_load != 0) begin
                m_load <= m_load - 1;
                if (m_load == 1) begin
                    m_valid <= 1'b1;
                    m_idx   <= 0;
                end
            end
            if (m_valid && i_ot_ready) begin
                if (m_idx == N - 1) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_valid", o_ot_valid, 0);
            check("rst_last", o_ot_last, 0);
            check("rst_busy", o_busy, 0);
            check("rst_drop", o_drop, 0);
            check("rst_fmap", o_ot_fmap, 0);
            hs_in_frame <= 0;
        end else begin
            check("valid", o_ot_valid, m_valid);
            check("busy", o_busy, m_busy);
            check("drop", o_drop, m_drop);
            if (m_valid) begin
                check("fmap", o_ot_fmap, m_mem[m_idx]);
                check("last", o_ot_last, m_idx == N - 1);
            end
            if (o_ot_valid && i_ot_ready) begin
                beats <= beats + 1;
                if (o_ot_last) begin
                    last_idx    <= hs_in_frame;
                    hs_in_frame <= 0;
                end else begin
                    hs_in_frame <= hs_in_frame + 1;
                end
            end
            if (o_drop) drops <= drops + 1;
        end
    end

    initial begin
        i_ot_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       i_ot_ready = 1'b1;
                1:       i_ot_ready = 1'($urandom_range(0, 1));
                default: i_ot_ready = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [7:0] tag, input int start, input int count, input int gap_max);
        for (int a = start; a < start + count; a++) begin
            if (a > start && gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
            i_in_valid = 1'b1;
            i_in_fmap  = pix(tag, a);
            step();
            i_in_valid = 1'b0;
        end
    endtask

    // Called right after the edge that writes the last pixel.
    task automatic check_start(input logic [7:0] tag);
        step();
        check("lat_edge1_valid", o_ot_valid, 0);
        check("lat_edge1_busy", o_busy, 1);
        step();
        check("lat_edge2_valid", o_ot_valid, 1);
        check("first_pixel", o_ot_fmap, pix(tag, 0));
    endtask

    task automatic wait_done(input string name);
        int b = 0;
        while (o_busy && b < 5000) begin
            step();
            b++;
        end
        if (b >= 5000) timeout_fail(name);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, nd, a, guard;
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        ready_mode = 0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: contiguous fill, ready tied high
        b0 = beats;
        send_beats(8'h11, 0, N, 0);
        check_start(8'h11);
        wait_done("t1_done");
        check("t1_beats", beats - b0, N);
        check("t1_last_idx", last_idx, N - 1);
        check("t1_busy_after", o_busy, 0);

        // 2: random backpressure
        ready_mode = 1;
        b0 = beats;
        send_beats(8'h22, 0, N, 0);
        check_start(8'h22);
        wait_done("t2_done");
        check("t2_beats", beats - b0, N);
        check("t2_last_idx", last_idx, N - 1);

        // 3: beats injected while streaming are dropped
        b0 = beats;
        send_beats(8'h33, 0, N, 0);
        repeat (4) step();
        d0 = drops;
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1;
            i_in_fmap  = pix(8'hEE, i);
            step();
            i_in_valid = 1'b0;
            step();
        end
        step();
        check("t3_drops", drops - d0, 5);
        wait_done("t3_done");
        check("t3_beats", beats - b0, N);
        ready_mode = 0;
        b0 = beats;
        send_beats(8'h44, 0, N, 0);
        check_start(8'h44);
        wait_done("t3b_done");
        check("t3b_beats", beats - b0, N);

        // 4: reset mid-fill discards partial frame
        send_beats(8'h55, 0, 70, 0);
        reset_n = 1'b0;
        #2;
        check("t4_rst_valid", o_ot_valid, 0);
        check("t4_rst_busy", o_busy, 0);
        check("t4_rst_fmap", o_ot_fmap, 0);
        step();
        reset_n = 1'b1;
        step();
        b0 = beats;
        send_beats(8'hA6, 0, N, 1);
        check_start(8'hA6);
        wait_done("t4_done");
        check("t4_beats", beats - b0, N);
        check("t4_last_idx", last_idx, N - 1);

        // 5: async reset while stalled mid-stream
        send_beats(8'h66, 0, N, 2);
        check_start(8'h66);
        guard = 0;
        while (hs_in_frame < 40 && guard < 1000) begin
            step();
            guard++;
        end
        if (guard >= 1000) timeout_fail("t5_reach40");
        ready_mode = 2;
        step();
        step();
        check("t5_stalled_valid", o_ot_valid, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_async_valid", o_ot_valid, 0);
        check("t5_async_busy", o_busy, 0);
        check("t5_async_last", o_ot_last, 0);
        step();
        reset_n = 1'b1;
        ready_mode = 1;
        step();

        // 6: back-to-back frames, second frame overlaps first replay
        b0 = beats;
        send_beats(8'h77, 0, N, 3);
        d0 = drops;
        nd = 0;
        a = 0;
        guard = 0;
        while (a < N && guard < 20000) begin
            repeat ($urandom_range(0, 3)) step();
            i_in_valid = 1'b1;
            i_in_fmap  = pix(8'h88, a);
            if (o_busy) nd++;
            else a++;
            step();
            i_in_valid = 1'b0;
            guard++;
        end
        if (guard >= 20000) timeout_fail("t6_send");
        wait_done("t6_done");
        check("t6_drops", drops - d0, nd);
        check("t6_beats", beats - b0, 2 * N);
        check("t6_last_idx", last_idx, N - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
